receiver_frame_packer: RTL and testbench

//  Downstream consumer of single_receiver_manager. Polls avl_blocks_nb, reads every stored block by index via

---
 rtl/receiver_frame_packer_if.sv | 22 ++
 rtl/receiver_frame_packer.sv | 126 ++++++++++++
 tb/tb_receiver_frame_packer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/receiver_frame_packer_if.sv
// Link between the packer, the receiver block RAM and the host-link byte stream.
interface receiver_frame_packer_if;
  logic [7:0]  avl_blocks_nb;
  logic [40:0] block_wanted;
  logic        data_ready;
  logic [7:0]  block_wanted_number;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        frame_done;
  logic [7:0]  timeout_cnt;

  modport master (
    input  avl_blocks_nb, block_wanted, data_ready, byte_ready,
    output block_wanted_number, byte_out, byte_valid, frame_done, timeout_cnt
  );

  modport slave (
    output avl_blocks_nb, block_wanted, data_ready, byte_ready,
    input  block_wanted_number, byte_out, byte_valid, frame_done, timeout_cnt
  );
endinterface

// File: rtl/receiver_frame_packer.sv
// Scans every stored receiver block by index and emits each one as a checksummed frame:
// sync, receiver id, index, six data bytes (MSB first), XOR checksum of bytes 1..8.
module receiver_frame_packer #(
  parameter logic [7:0]  RECEIVER_ID    = 8'd0,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_96MHz,
  input  logic                    reset_n,
  receiver_frame_packer_if.master bus
);

  localparam int unsigned CW      = 16;
  localparam int unsigned BCNT_W  = 4;
  localparam int unsigned SHIFT_W = 48;

  typedef enum logic [2:0] {ST_IDLE, ST_REQUEST, ST_WAIT, ST_SEND, ST_NEXT} state_t;

  state_t               state;
  logic [7:0]           n_blocks;
  logic [7:0]           idx;
  logic [CW-1:0]        settle_cnt;
  logic [CW-1:0]        wait_cnt;
  logic [BCNT_W-1:0]    byte_cnt;
  logic [7:0]           chk;
  logic [SHIFT_W-1:0]   shreg;
  logic [7:0]           block_wanted_number;
  logic [7:0]           byte_out;
  logic                 byte_valid;
  logic                 frame_done;
  logic [7:0]           timeout_cnt;

  assign bus.block_wanted_number = block_wanted_number;
  assign bus.byte_out            = byte_out;
  assign bus.byte_valid          = byte_valid;
  assign bus.frame_done          = frame_done;
  assign bus.timeout_cnt         = timeout_cnt;

  // Scan FSM with registered outputs
  always_ff @(posedge clk_96MHz or negedge reset_n) begin
    if (!reset_n) begin
      state               <= ST_IDLE;
      n_blocks            <= 8'd0;
      idx                 <= 8'd0;
      settle_cnt          <= '0;
      wait_cnt            <= '0;
      byte_cnt            <= '0;
      chk                 <= 8'd0;
      shreg               <= '0;
      block_wanted_number <= 8'd0;
      byte_out            <= 8'd0;
      byte_valid          <= 1'b0;
      frame_done          <= 1'b0;
      timeout_cnt         <= 8'd0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.avl_blocks_nb != 8'd0) begin
            n_blocks <= bus.avl_blocks_nb;
            idx      <= 8'd0;
            state    <= ST_REQUEST;
          end
        end
        ST_REQUEST: begin
          block_wanted_number <= idx;
          settle_cnt          <= '0;
          wait_cnt            <= '0;
          state               <= ST_WAIT;
        end
        ST_WAIT: begin
          // data_ready is meaningless until the RAM read has settled on the new index
          if (settle_cnt < CW'(SETTLE_CYCLES)) begin
            settle_cnt <= settle_cnt + CW'(1);
          end else if (bus.data_ready) begin
            shreg      <= {7'd0, bus.block_wanted};
            byte_cnt   <= '0;
            chk        <= 8'd0;
            byte_out   <= SYNC_BYTE;
            byte_valid <= 1'b1;
            state      <= ST_SEND;
          end else if ((wait_cnt + CW'(1)) >= CW'(TIMEOUT_CYCLES)) begin
            if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
            state <= ST_NEXT;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        ST_SEND: begin
          if (bus.byte_ready) begin
            if (byte_cnt == BCNT_W'(9)) begin
              byte_valid <= 1'b0;
              frame_done <= 1'b1;
              state      <= ST_NEXT;
            end else begin
              byte_cnt <= byte_cnt + BCNT_W'(1);
              if (byte_cnt != BCNT_W'(0)) chk <= chk ^ byte_out;
              // Data bytes come off the top of the shift register, one shift per accepted byte
              case (byte_cnt)
                BCNT_W'(0): byte_out <= RECEIVER_ID;
                BCNT_W'(1): byte_out <= idx;
                BCNT_W'(2): byte_out <= shreg[47:40];
                BCNT_W'(8): byte_out <= chk ^ byte_out;
                default: begin
                  byte_out <= shreg[39:32];
                  shreg    <= shreg << 8;
                end
              endcase
            end
          end
        end
        ST_NEXT: begin
          if (idx == (n_blocks - 8'd1)) begin
            state <= ST_IDLE;
          end else begin
            idx   <= idx + 8'd1;
            state <= ST_REQUEST;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_receiver_frame_packer.sv
// Scoreboard bench for receiver_frame_packer: expected frame bytes are queued as scans are launched
// and checked byte by byte as the DUT hands them over.
module tb_receiver_frame_packer;

  logic clk_96MHz = 1'b0;
  logic reset_n   = 1'b0;
  always #5 clk_96MHz = ~clk_96MHz;

  receiver_frame_packer_if bus();

  receiver_frame_packer #(.RECEIVER_ID(8'd3)) dut (
    .clk_96MHz (clk_96MHz),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  // Receiver RAM model: data and readiness per index
  logic [40:0] mem        [256];
  logic        ready_mask [256];
  assign bus.block_wanted = mem[bus.block_wanted_number];
  assign bus.data_ready   = ready_mask[bus.block_wanted_number];

  typedef struct packed {
    logic [7:0] b;
    logic [7:0] idx;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   frames_seen = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic push_frame(input logic [7:0] idx, input logic [40:0] d);
    logic [47:0] w;
    logic [7:0]  fb [10];
    w     = {7'd0, d};
    fb[0] = 8'hA5;
    fb[1] = 8'd3;
    fb[2] = idx;
    for (int j = 0; j < 6; j++) fb[3+j] = w[47-8*j -: 8];
    fb[9] = 8'd0;
    for (int j = 1; j <= 8; j++) fb[9] = fb[9] ^ fb[j];
    for (int j = 0; j < 10; j++) exp_q.push_back('{fb[j], idx, (j == 9)});
  endtask

  task automatic cyc(input int k);
    repeat (k) @(posedge clk_96MHz);
    #1;
  endtask

  task automatic start_scan(input logic [7:0] n);
    bus.avl_blocks_nb = n;
    cyc(1);
    bus.avl_blocks_nb = 8'd0;
  endtask

  task automatic wait_q(input int thr, input int limit, input string tag);
    int c = 0;
    while (exp_q.size() > thr && c < limit) begin
      cyc(1);
      c++;
    end
    check_eq(tag, 64'(exp_q.size() <= thr), 64'd1);
  endtask

  task automatic drain(input int limit, input string tag);
    wait_q(0, limit, tag);
    cyc(4);
  endtask

  // Output monitor: byte scoreboard, stall stability, frame_done timing
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte  = 8'd0;
  logic       exp_done   = 1'b0;

  always @(negedge clk_96MHz) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
      exp_done   = 1'b0;
    end else begin
      exp_t e;
      if (prev_stall) begin
        check_eq("hold_valid", 64'(bus.byte_valid), 64'd1);
        check_eq("hold_byte", 64'(bus.byte_out), 64'(prev_byte));
      end
      if (exp_done || bus.frame_done) check_eq("frame_done", 64'(bus.frame_done), 64'(exp_done));
      if (bus.frame_done) frames_seen++;
      exp_done = 1'b0;
      if (bus.byte_valid && bus.byte_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_byte", 64'(bus.byte_out), 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check_eq("byte", 64'(bus.byte_out), 64'(e.b));
          check_eq("block_wanted_number", 64'(bus.block_wanted_number), 64'(e.idx));
          exp_done = e.last;
        end
      end
      prev_stall = bus.byte_valid && !bus.byte_ready;
      prev_byte  = bus.byte_out;
    end
  end

  initial begin
    logic [7:0] t1 [10];
    int         lat;
    t1 = '{8'hA5, 8'h03, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'h91};
    for (int i = 0; i < 256; i++) begin
      mem[i]        = 41'({$urandom(), $urandom()});
      ready_mask[i] = 1'b1;
    end
    bus.avl_blocks_nb = 8'd0;
    bus.byte_ready    = 1'b1;

    cyc(3);
    check_eq("rst_byte_valid", 64'(bus.byte_valid), 64'd0);
    check_eq("rst_byte_out", 64'(bus.byte_out), 64'd0);
    check_eq("rst_bwn", 64'(bus.block_wanted_number), 64'd0);
    check_eq("rst_timeout_cnt", 64'(bus.timeout_cnt), 64'd0);
    check_eq("rst_frame_done", 64'(bus.frame_done), 64'd0);
    reset_n = 1'b1;
    cyc(2);

    // Single block, known frame contents and request-to-first-byte latency
    mem[0] = 41'h1_2345_6789A;
    for (int j = 0; j < 10; j++) exp_q.push_back('{t1[j], 8'd0, (j == 9)});
    start_scan(8'd1);
    lat = 0;
    while (!bus.byte_valid && lat < 50) begin
      cyc(1);
      lat++;
    end
    check_eq("first_byte_latency", 64'(lat), 64'd4);
    drain(100, "drain_single");

    // Three-block scan
    for (int i = 0; i < 3; i++) push_frame(8'(i), mem[i]);
    start_scan(8'd3);
    drain(300, "drain_three");

    // Back-pressure mid-frame
    mem[0] = 41'h0_DEAD_BEEF1;
    push_frame(8'd0, mem[0]);
    start_scan(8'd1);
    wait_q(6, 100, "reach_stall_point");
    bus.byte_ready = 1'b0;
    cyc(5);
    bus.byte_ready = 1'b1;
    drain(100, "drain_stall");

    // Index 1 never becomes ready and is skipped
    ready_mask[1] = 1'b0;
    push_frame(8'd0, mem[0]);
    push_frame(8'd2, mem[2]);
    start_scan(8'd3);
    drain(800, "drain_timeout");
    check_eq("timeout_cnt_after_skip", 64'(bus.timeout_cnt), 64'd1);
    ready_mask[1] = 1'b1;

    // Block count grows mid-scan: current scan keeps its snapshot
    for (int i = 0; i < 2; i++) push_frame(8'(i), mem[i]);
    for (int i = 0; i < 6; i++) push_frame(8'(i), mem[i]);
    bus.avl_blocks_nb = 8'd2;
    cyc(1);
    bus.avl_blocks_nb = 8'd6;
    wait_q(59, 300, "reach_second_scan");
    bus.avl_blocks_nb = 8'd0;
    drain(800, "drain_grow");
    check_eq("timeout_cnt_unchanged", 64'(bus.timeout_cnt), 64'd1);

    // Reset in the middle of a frame
    push_frame(8'd0, mem[0]);
    start_scan(8'd1);
    wait_q(6, 100, "reach_reset_point");
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_byte_valid", 64'(bus.byte_valid), 64'd0);
    check_eq("async_rst_byte_out", 64'(bus.byte_out), 64'd0);
    check_eq("async_rst_bwn", 64'(bus.block_wanted_number), 64'd0);
    check_eq("async_rst_timeout_cnt", 64'(bus.timeout_cnt), 64'd0);
    exp_q.delete();
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
    mem[0] = 41'h1_FFFF_00001;
    push_frame(8'd0, mem[0]);
    start_scan(8'd1);
    drain(100, "drain_after_reset");
    check_eq("timeout_cnt_after_reset", 64'(bus.timeout_cnt), 64'd0);

    check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
    check_eq("frames_completed", 64'(frames_seen), 64'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
